// File: rtl/vote_result_tally.sv
// Post-poll results stage: snapshots four vote counts, finds the leader one
// comparison per cycle, then rotates each candidate's count across the LEDs.
module vote_result_tally #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned DWELL = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] vc1,
  input  logic [CNT_W-1:0] vc2,
  input  logic [CNT_W-1:0] vc3,
  input  logic [CNT_W-1:0] vc4,
  output logic             busy,
  output logic             done,
  output logic [1:0]       winner,
  output logic [CNT_W-1:0] win_count,
  output logic             tie,
  output logic             no_votes,
  output logic [7:0]       led,
  output logic [3:0]       led_sel
);

  localparam int unsigned DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL - 1);
  localparam int unsigned LED_W = (CNT_W < 8) ? CNT_W : 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    ROTATE  = 2'd2
  } state_t;

  state_t state, next_state;

  logic [CNT_W-1:0] snap [4];
  logic [1:0]       best_idx;
  logic [CNT_W-1:0] best_val;
  logic             tie_acc;
  logic [1:0]       idx;
  logic [DW_W-1:0]  dwell;
  logic [1:0]       disp;

  logic [CNT_W-1:0] cur;
  logic             cur_gt;
  logic             cur_eq;
  logic [1:0]       next_disp;
  logic             start_ok;
  logic             commit_nv;

  function automatic logic [7:0] to_led(input logic [CNT_W-1:0] v);
    logic [7:0] r;
    r = '0;
    r[LED_W-1:0] = v[LED_W-1:0];
    return r;
  endfunction

  function automatic logic [3:0] onehot(input logic [1:0] i);
    logic [3:0] r;
    r = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    start_ok   = 1'b0;
    case (state)
      IDLE: begin
        start_ok = start;
        if (start) next_state = COMPARE;
      end
      // idx wraps to 0 after candidate 4 is processed; that cycle is the commit.
      COMPARE: if (idx == 2'd0) next_state = ROTATE;
      ROTATE: begin
        start_ok = start;
        if (start) next_state = COMPARE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    cur       = snap[idx];
    cur_gt    = cur > best_val;
    cur_eq    = cur == best_val;
    next_disp = disp + 2'd1;
    commit_nv = best_val == '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < 4; i++) snap[i] <= '0;
      best_idx  <= '0;
      best_val  <= '0;
      tie_acc   <= 1'b0;
      idx       <= '0;
      dwell     <= '0;
      disp      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      winner    <= '0;
      win_count <= '0;
      tie       <= 1'b0;
      no_votes  <= 1'b0;
      led       <= '0;
      led_sel   <= '0;
    end else begin
      done <= 1'b0;
      if (start_ok) begin
        snap[0]  <= vc1;
        snap[1]  <= vc2;
        snap[2]  <= vc3;
        snap[3]  <= vc4;
        best_idx <= 2'd0;
        best_val <= vc1;
        tie_acc  <= 1'b0;
        idx      <= 2'd1;
        busy     <= 1'b1;
        led      <= '0;
        led_sel  <= '0;
        dwell    <= '0;
        disp     <= '0;
      end else if (state == COMPARE) begin
        if (idx != 2'd0) begin
          if (cur_gt) begin
            best_idx <= idx;
            best_val <= cur;
            tie_acc  <= 1'b0;
          end else if (cur_eq) begin
            tie_acc <= 1'b1;
          end
          idx <= idx + 2'd1;
        end else begin
          winner    <= best_idx;
          win_count <= best_val;
          no_votes  <= commit_nv;
          tie       <= tie_acc & ~commit_nv;
          done      <= 1'b1;
          busy      <= 1'b0;
          led       <= to_led(snap[0]);
          led_sel   <= 4'b0001;
          dwell     <= '0;
          disp      <= 2'd0;
        end
      end else if (state == ROTATE) begin
        if (dwell == DWELL_LAST) begin
          dwell   <= '0;
          disp    <= next_disp;
          led     <= to_led(snap[next_disp]);
          led_sel <= onehot(next_disp);
        end else begin
          dwell <= dwell + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vote_result_tally.sv
// Directed bench for vote_result_tally with DWELL=4 and hand-computed results.
module tb_vote_result_tally;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] vc1, vc2, vc3, vc4;
  logic       busy, done, tie, no_votes;
  logic [1:0] winner;
  logic [7:0] win_count, led;
  logic [3:0] led_sel;

  int total = 0;
  int bad   = 0;

  vote_result_tally #(.CNT_W(8), .DWELL(4)) dut (
    .clk(clk), .reset(reset), .start(start),
    .vc1(vc1), .vc2(vc2), .vc3(vc3), .vc4(vc4),
    .busy(busy), .done(done), .winner(winner), .win_count(win_count),
    .tie(tie), .no_votes(no_votes), .led(led), .led_sel(led_sel)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".busy"}, 32'(busy), 0);
    chk({tag, ".done"}, 32'(done), 0);
    chk({tag, ".winner"}, 32'(winner), 0);
    chk({tag, ".win_count"}, 32'(win_count), 0);
    chk({tag, ".tie"}, 32'(tie), 0);
    chk({tag, ".no_votes"}, 32'(no_votes), 0);
    chk({tag, ".led"}, 32'(led), 0);
    chk({tag, ".led_sel"}, 32'(led_sel), 0);
  endtask

  task automatic chk_result(input string tag, input int w, input int c, input int t, input int nv);
    chk({tag, ".done"}, 32'(done), 1);
    chk({tag, ".busy"}, 32'(busy), 0);
    chk({tag, ".winner"}, 32'(winner), 32'(w));
    chk({tag, ".win_count"}, 32'(win_count), 32'(c));
    chk({tag, ".tie"}, 32'(tie), 32'(t));
    chk({tag, ".no_votes"}, 32'(no_votes), 32'(nv));
  endtask

  // Called right after the commit edge; walks 4 candidates x 4 cycles plus the wrap.
  task automatic rot_check(input string tag, input int a, input int b, input int c, input int d);
    int vals [4];
    vals = '{a, b, c, d};
    for (int i = 0; i < 17; i++) begin
      chk({tag, ".led"}, 32'(led), 32'(vals[(i / 4) % 4]));
      chk({tag, ".led_sel"}, 32'(led_sel), 32'(1) << ((i / 4) % 4));
      chk({tag, ".done"}, 32'(done), (i == 0) ? 1 : 0);
      step();
    end
  endtask

  task automatic evaluate(input int a, input int b, input int c, input int d);
    vc1 = 8'(a); vc2 = 8'(b); vc3 = 8'(c); vc4 = 8'(d);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("eval.busy_k", 32'(busy), 1);
    repeat (4) step();
  endtask

  initial begin
    reset = 1'b1; start = 1'b0;
    vc1 = '0; vc2 = '0; vc3 = '0; vc4 = '0;
    repeat (3) step();
    reset = 1'b0;
    step();
    chk_zero("reset");
    step();
    chk_zero("idle");

    // Basic evaluation with snapshot isolation and full rotation
    vc1 = 8'd5; vc2 = 8'd9; vc3 = 8'd3; vc4 = 8'd7;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t1.busy_k", 32'(busy), 1);
    chk("t1.done_k", 32'(done), 0);
    chk("t1.led_k", 32'(led), 0);
    chk("t1.led_sel_k", 32'(led_sel), 0);
    vc1 = 8'd1; vc2 = 8'd1; vc3 = 8'd1; vc4 = 8'd1;
    for (int i = 1; i < 4; i++) begin
      step();
      chk("t1.busy_mid", 32'(busy), 1);
      chk("t1.done_mid", 32'(done), 0);
      chk("t1.winner_hold", 32'(winner), 0);
    end
    step();
    chk_result("t1", 1, 9, 0, 0);
    rot_check("t1.rot", 5, 9, 3, 7);

    evaluate(6, 2, 6, 1);
    chk_result("t2", 0, 6, 1, 0);
    evaluate(4, 8, 8, 8);
    chk_result("t3", 1, 8, 1, 0);
    evaluate(0, 0, 0, 0);
    chk_result("t4", 0, 0, 0, 1);
    rot_check("t4.rot", 0, 0, 0, 0);

    // start re-asserted during COMPARE is ignored
    vc1 = 8'd5; vc2 = 8'd9; vc3 = 8'd3; vc4 = 8'd7;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t5.busy", 32'(busy), 1);
    step();
    chk("t5.done_early", 32'(done), 0);
    step();
    chk_result("t5", 1, 9, 0, 0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("t5.no_second_done", 32'(done), 0);
      chk("t5.not_busy", 32'(busy), 0);
    end

    // start in ROTATE: led blanked while busy, old results held
    vc1 = 8'd2; vc2 = 8'd2; vc3 = 8'd1; vc4 = 8'd3;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t6.led_busy", 32'(led), 0);
    chk("t6.led_sel_busy", 32'(led_sel), 0);
    chk("t6.busy", 32'(busy), 1);
    chk("t6.winner_hold", 32'(winner), 1);
    chk("t6.count_hold", 32'(win_count), 9);
    repeat (4) step();
    chk_result("t6", 3, 3, 0, 0);
    chk("t6.led", 32'(led), 2);

    // start held continuously re-evaluates right after each commit
    vc1 = 8'd1; vc2 = 8'd4; vc3 = 8'd4; vc4 = 8'd2;
    start = 1'b1;
    repeat (5) step();
    chk_result("t7a", 1, 4, 1, 0);
    step();
    chk("t7.rebusy", 32'(busy), 1);
    chk("t7.redone", 32'(done), 0);
    repeat (4) step();
    chk_result("t7b", 1, 4, 1, 0);
    start = 1'b0;
    step();
    chk("t7.idle_busy", 32'(busy), 0);

    // reset at edge k+2 of an evaluation
    vc1 = 8'd7; vc2 = 8'd1; vc3 = 8'd2; vc4 = 8'd3;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    reset = 1'b1;
    step();
    chk_zero("t8.reset");
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk_zero("t8.after");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
